ram_req_arbiter: RTL and testbench
==================================

# ram_req_arbiter

Two-initiator request arbiter that drives the single-port-side signals of one port of the dual-port data RAM. It converts byte-addressed req/gnt/rvalid transactions from two masters (e.g. core data port and debug/DMA master) into word-addressed en/addr/we/be cycles. It generates the response phase from the RAM's fixed one-cycle read latency. It sits between the interconnect initiators and one port (A or B) of the RAM wrapper.

## Interface
- ADDR_WIDTH, 12, RAM word-address width; the byte address space is ADDR_WIDTH+2 bits.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i[1:0]  in  2  per-initiator request.
- addr_i[n]  in  32  byte address, n = 0,1.
- we_i[n]  in  1  1 = write.
- be_i[n]  in  4  byte enables.
- wdata_i[n]  in  32  write data.
- gnt_o[1:0]  out  2  request accepted this cycle (combinational).
- rvalid_o[1:0]  out  2  response valid.
- rdata_o[n]  out  32  read data; 0 for writes and errors.
- err_o[1:0]  out  2  error response, qualified by rvalid_o.
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_WIDTH  word address = addr_i[ADDR_WIDTH+1:2].
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_en_o.

## Operation
- At most one grant per cycle; a new transaction may be granted every cycle with no bubbles.
- Arbitration:
  - Only one req_i high: that initiator is granted.
  - Both high: grant the initiator not granted most recently (round-robin). The last-granted pointer updates only on a grant.
- On a grant, ram_en_o/ram_we_o/ram_be_o/ram_wdata_o/ram_addr_o are driven combinationally from the granted initiator in the same cycle.
- With no grant, ram_en_o=0 and ram_we_o=0.
- addr_i[1:0] is ignored; be_i is passed through unchanged.
- Response register holds the granted id, a write flag and an err flag; it is loaded on each grant.
- Response occurs exactly one cycle after the grant, for reads and writes alike:
  - rvalid_o[id]=1 for that single cycle.
  - rdata_o[id]: ram_rdata_i for a read; 32'h0 for a write or an error.
- The non-addressed initiator sees rvalid=0 and rdata=0.
- An initiator must hold req/addr/we/be/wdata stable until it sees gnt; the block does not sample without gnt.

## Timing
- Grant latency: 0 cycles (gnt is combinational on req and the pointer).
- Response latency: exactly 1 cycle after gnt; no backpressure on responses.
- Reset values: gnt_o=0 (given req_i=0), rvalid_o=0, err_o=0, rdata_o=0, ram_en_o=0, ram_we_o=0. The last-granted pointer resets to 1, so initiator 0 wins the first contention.
- Back-to-back grants to different initiators: each response goes to its own id on consecutive cycles.
- Simultaneous response and new grant in the same cycle: both are legal; the response belongs to the previous grant.
- Reset asserted mid-transaction: any pending response is dropped, and rvalid_o=0 immediately (asynchronously). The pointer returns to its reset value.

## Configuration
- RAM_ARB_RANGE_CHK_EN defined:
  - Any set bit in addr_i[31:ADDR_WIDTH+2] marks the request out of range.
  - The request is still granted, but ram_en_o stays 0 that cycle.
  - Next cycle: rvalid_o=1, err_o=1, rdata_o=0.
  - The round-robin pointer advances normally.
- RAM_ARB_RANGE_CHK_EN undefined:
  - Upper address bits are ignored (the address aliases into the RAM).
  - err_o is tied to 0.

## Test plan
- Single read: RAM pre-loaded with word 5 = 32'hDEADBEEF; initiator 0 reads addr 32'h14 -> gnt_o=2'b01 with ram_en_o=1 and ram_addr_o=5 in the same cycle; next cycle rvalid_o[0]=1 and rdata_o[0]=32'hDEADBEEF.
- Byte write then read: initiator 1 writes addr 32'h8 with be=4'b0010 and wdata=32'h0000AB00 into a zeroed RAM -> rvalid_o[1] next cycle with rdata 0; a subsequent read of 32'h8 -> 32'h0000AB00.
- Contention: both initiators request continuously for 4 cycles after reset -> grants 0,1,0,1, and rvalid to ids 0,1,0,1 delayed by one cycle.
- Back-to-back: initiator 0 issues reads of words 0..3 on consecutive cycles -> 4 consecutive rvalid cycles returning the words in order, with no gaps.
- Range check (macro defined, ADDR_WIDTH=12): read addr 32'h0001_0000 -> gnt=1 and ram_en_o=0; next cycle rvalid=1, err=1, rdata=0. With the macro undefined, the same read returns word 0 with err=0.
- Reset mid-transaction: assert rst_n=0 in the cycle after a grant -> rvalid_o is 0 immediately; after release, contention grants initiator 0 first.

Source files
------------

// File: rtl/ram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_req_arbiter_if
//  Description : Bundle of the two-initiator request/response bus and the
//                RAM-port side signals used by ram_req_arbiter.
//                Initiator fields are packed [1:0] arrays indexed by
//                initiator id.
//  Ports (slave view = arbiter):
//    in  : req[1:0], addr[n], we[n], be[n], wdata[n], ram_rdata
//    out : gnt[1:0], rvalid[1:0], rdata[n], err[1:0],
//          ram_en, ram_addr, ram_we, ram_be, ram_wdata
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_req_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    // initiator side
    logic [1:0]        req;
    logic [1:0][31:0]  addr;
    logic [1:0]        we;
    logic [1:0][3:0]   be;
    logic [1:0][31:0]  wdata;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [1:0][31:0]  rdata;
    logic [1:0]        err;

    // RAM port side
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    modport slave (
        input  req, addr, we, be, wdata, ram_rdata,
        output gnt, rvalid, rdata, err,
               ram_en, ram_addr, ram_we, ram_be, ram_wdata
    );

    modport master (
        output req, addr, we, be, wdata, ram_rdata,
        input  gnt, rvalid, rdata, err,
               ram_en, ram_addr, ram_we, ram_be, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_req_arbiter
//  Description : Round-robin arbiter between two byte-addressed req/gnt/rvalid
//                initiators and one word-addressed port of a RAM with fixed
//                one-cycle read latency. Grant and RAM command are
//                combinational; the response follows exactly one cycle later.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - ram_req_arbiter_if.slave (initiator + RAM signals)
//  Options     : RAM_ARB_RANGE_CHK_EN - when defined, requests with any set
//                address bit above the RAM range are granted without a RAM
//                access and answered with err=1, rdata=0.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_req_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_req_arbiter_if.slave  bus
);

    logic        r_last;      // id of the most recently granted initiator
    logic        r_rsp_vld;
    logic        r_rsp_id;
    logic        r_rsp_we;
    logic        r_rsp_err;

    logic        w_any;
    logic        w_id;
    logic        w_oor;
    logic        w_en;
    logic [31:0] w_addr;

    assign w_any = |bus.req;

    // Initiator 1 wins if it is the only requester, or on contention when
    // initiator 0 was granted last.
    assign w_id   = bus.req[1] & (~bus.req[0] | ~r_last);
    assign w_addr = bus.addr[w_id];

    generate
        if (ADDR_WIDTH + 2 < 32) begin : g_upper_bits
`ifdef RAM_ARB_RANGE_CHK_EN
            assign w_oor = |w_addr[31:ADDR_WIDTH+2];
`else
            // Upper bits alias into the RAM.
            assign w_oor = 1'b0;
`endif
            logic w_unused_bits;
            assign w_unused_bits = ^{w_addr[1:0], w_addr[31:ADDR_WIDTH+2]};
        end else begin : g_no_upper_bits
            assign w_oor = 1'b0;
            logic w_unused_bits;
            assign w_unused_bits = ^w_addr[1:0];
        end
    endgenerate

    assign w_en = w_any & ~w_oor;

    assign bus.gnt       = w_any ? (w_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.ram_en    = w_en;
    assign bus.ram_we    = w_en & bus.we[w_id];
    assign bus.ram_addr  = w_addr[ADDR_WIDTH+1:2];
    assign bus.ram_be    = bus.be[w_id];
    assign bus.ram_wdata = bus.wdata[w_id];

    // Response register: loaded on every grant, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= 1'b1;
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= 1'b0;
            r_rsp_we  <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_vld <= w_any;
            if (w_any) begin
                r_last    <= w_id;
                r_rsp_id  <= w_id;
                r_rsp_we  <= bus.we[w_id];
                r_rsp_err <= w_oor;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            logic w_hit;
            assign w_hit            = r_rsp_vld & (r_rsp_id == 1'(gi));
            assign bus.rvalid[gi]   = w_hit;
            // RAM read data is only forwarded for a successful read.
            assign bus.rdata[gi]    = (w_hit & ~r_rsp_we & ~r_rsp_err) ?
                                      bus.ram_rdata : 32'h0;
`ifdef RAM_ARB_RANGE_CHK_EN
            assign bus.err[gi]      = w_hit & r_rsp_err;
`else
            assign bus.err[gi]      = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_req_arbiter
//  Description : Self-checking bench for ram_req_arbiter. A behavioural model
//                predicts grants, RAM commands and responses every cycle;
//                directed sequences pin hand-computed values; a randomized
//                phase exercises contention, writes, reads and (optionally)
//                out-of-range addresses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_req_arbiter;

    localparam int AW    = 12;
    localparam int WORDS = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_req_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    ram_req_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM with one-cycle read latency ----------------
    logic [31:0] mem    [0:WORDS-1];
    logic [31:0] shadow [0:WORDS-1];

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[3] = 32'h33333333;
        mem[5] = 32'hDEADBEEF;
        bus.ram_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (bus.ram_en) begin
                if (bus.ram_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.ram_be[b]) mem[bus.ram_addr][b*8 +: 8] = bus.ram_wdata[b*8 +: 8];
                end else begin
                    bus.ram_rdata <= mem[bus.ram_addr];
                end
            end
        end
    end

    // ---------------- behavioural model + compare ----------------
    int          m_last = 1;
    bit          m_pv   = 1'b0;
    int          m_pid  = 0;
    logic [31:0] m_pdata = 32'h0;
    bit          m_perr = 1'b0;
    logic [1:0]  g_seen = 2'b00;

    always @(negedge clk) begin
        int          g;
        int          w;
        bit          oor;
        bit          ew;
        logic [31:0] a;
        logic [1:0]  eg, erv, eerr;
        logic [31:0] erd0, erd1;

        if (!rst_n) begin
            m_last = 1;
            m_pv   = 1'b0;
        end

        case (bus.req)
            2'b00:   g = -1;
            2'b01:   g = 0;
            2'b10:   g = 1;
            default: g = (m_last == 0) ? 1 : 0;
        endcase
        eg  = (g < 0) ? 2'b00 : (2'b01 << g);
        oor = 1'b0;
        a   = 32'h0;
        ew  = 1'b0;
        if (g >= 0) begin
            a = bus.addr[g];
`ifdef RAM_ARB_RANGE_CHK_EN
            oor = (a >> (AW + 2)) != 0;
`endif
            if (!oor) ew = bus.we[g];
        end

        chk("gnt", {30'h0, bus.gnt}, {30'h0, eg});
        chk("ram_en", {31'h0, bus.ram_en}, {31'h0, (g >= 0 && !oor)});
        chk("ram_we", {31'h0, bus.ram_we}, {31'h0, ew});
        if (g >= 0 && !oor) begin
            chk("ram_addr", {20'h0, bus.ram_addr}, (a / 4) % WORDS);
            chk("ram_be", {28'h0, bus.ram_be}, {28'h0, bus.be[g]});
            chk("ram_wdata", bus.ram_wdata, bus.wdata[g]);
        end

        erv  = m_pv ? (2'b01 << m_pid) : 2'b00;
        eerr = (m_pv && m_perr) ? erv : 2'b00;
        erd0 = (m_pv && m_pid == 0) ? m_pdata : 32'h0;
        erd1 = (m_pv && m_pid == 1) ? m_pdata : 32'h0;
        chk("rvalid", {30'h0, bus.rvalid}, {30'h0, erv});
        chk("err", {30'h0, bus.err}, {30'h0, eerr});
        chk("rdata0", bus.rdata[0], erd0);
        chk("rdata1", bus.rdata[1], erd1);

        g_seen = bus.gnt;

        if (rst_n) begin
            m_pv = (g >= 0);
            if (g >= 0) begin
                m_pid  = g;
                m_last = g;
                m_perr = oor;
                w      = (a / 4) % WORDS;
                m_pdata = (oor || bus.we[g]) ? 32'h0 : shadow[w];
                if (!oor && bus.we[g])
                    for (int b = 0; b < 4; b++)
                        if (bus.be[g][b]) shadow[w][b*8 +: 8] = bus.wdata[g][b*8 +: 8];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #6;
    endtask

    task automatic gen(input int n);
        logic [31:0] a;
        if ($urandom_range(0, 99) < 65) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
            bus.req[n]   = 1'b1;
            bus.addr[n]  = a;
            bus.we[n]    = 1'($urandom_range(0, 1));
            bus.be[n]    = 4'($urandom_range(0, 15));
            bus.wdata[n] = $urandom;
        end else begin
            bus.req[n] = 1'b0;
        end
    endtask

    logic [31:0] bb_exp [4];

    initial begin
        for (int i = 0; i < WORDS; i++) shadow[i] = 32'h0;
        shadow[0] = 32'h11111111;
        shadow[1] = 32'h22222222;
        shadow[3] = 32'h33333333;
        shadow[5] = 32'hDEADBEEF;
        bb_exp[0] = 32'h11111111;
        bb_exp[1] = 32'h22222222;
        bb_exp[2] = 32'h0000AB00;
        bb_exp[3] = 32'h33333333;

        bus.req   = 2'b00;
        bus.addr  = '0;
        bus.we    = 2'b00;
        bus.be    = '0;
        bus.wdata = '0;

        // reset state
        step();
        mid();
        chk("rst_gnt", {30'h0, bus.gnt}, 32'h0);
        chk("rst_rvalid", {30'h0, bus.rvalid}, 32'h0);
        chk("rst_err", {30'h0, bus.err}, 32'h0);
        chk("rst_rdata0", bus.rdata[0], 32'h0);
        chk("rst_ram_en", {31'h0, bus.ram_en}, 32'h0);
        chk("rst_ram_we", {31'h0, bus.ram_we}, 32'h0);
        step();
        rst_n = 1'b1;

        // contention right after reset: 0,1,0,1
        bus.req     = 2'b11;
        bus.addr[0] = 32'h0;
        bus.addr[1] = 32'h4;
        bus.be      = {4'hF, 4'hF};
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("cont_gnt", {30'h0, bus.gnt}, (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            chk("cont_rvalid", {30'h0, bus.rvalid}, (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        bus.req = 2'b00;
        step();

        // single read of word 5
        bus.req = 2'b01; bus.addr[0] = 32'h14; bus.we[0] = 1'b0;
        mid();
        chk("rd_gnt", {30'h0, bus.gnt}, 32'h1);
        chk("rd_ram_en", {31'h0, bus.ram_en}, 32'h1);
        chk("rd_ram_addr", {20'h0, bus.ram_addr}, 32'h5);
        step();
        bus.req = 2'b00;
        chk("rd_rvalid", {30'h0, bus.rvalid}, 32'h1);
        chk("rd_rdata", bus.rdata[0], 32'hDEADBEEF);

        // byte write then read back
        bus.req = 2'b10; bus.addr[1] = 32'h8; bus.we[1] = 1'b1;
        bus.be[1] = 4'b0010; bus.wdata[1] = 32'h0000AB00;
        mid();
        chk("wr_gnt", {30'h0, bus.gnt}, 32'h2);
        chk("wr_ram_we", {31'h0, bus.ram_we}, 32'h1);
        chk("wr_ram_be", {28'h0, bus.ram_be}, 32'h2);
        step();
        chk("wr_rvalid", {30'h0, bus.rvalid}, 32'h2);
        chk("wr_rdata", bus.rdata[1], 32'h0);
        bus.we[1] = 1'b0;
        step();
        bus.req = 2'b00;
        chk("rb_rvalid", {30'h0, bus.rvalid}, 32'h2);
        chk("rb_rdata", bus.rdata[1], 32'h0000AB00);

        // back-to-back reads of words 0..3
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                chk("b2b_rvalid", {30'h0, bus.rvalid}, 32'h1);
                chk("b2b_rdata", bus.rdata[0], bb_exp[k-1]);
            end
            if (k < 4) begin
                bus.req = 2'b01; bus.addr[0] = 32'(k * 4); bus.we[0] = 1'b0;
            end else begin
                bus.req = 2'b00;
            end
            step();
        end

        // out-of-range / aliased address
        bus.req = 2'b01; bus.addr[0] = 32'h0001_0000; bus.we[0] = 1'b0;
        mid();
        chk("oor_gnt", {30'h0, bus.gnt}, 32'h1);
`ifdef RAM_ARB_RANGE_CHK_EN
        chk("oor_ram_en", {31'h0, bus.ram_en}, 32'h0);
`else
        chk("oor_ram_en", {31'h0, bus.ram_en}, 32'h1);
`endif
        step();
        bus.req = 2'b00;
        chk("oor_rvalid", {30'h0, bus.rvalid}, 32'h1);
`ifdef RAM_ARB_RANGE_CHK_EN
        chk("oor_err", {30'h0, bus.err}, 32'h1);
        chk("oor_rdata", bus.rdata[0], 32'h0);
`else
        chk("oor_err", {30'h0, bus.err}, 32'h0);
        chk("oor_rdata", bus.rdata[0], 32'h11111111);
`endif

        // reset during a pending response
        bus.req = 2'b10; bus.addr[1] = 32'h14; bus.we[1] = 1'b0;
        mid();
        chk("mr_gnt", {30'h0, bus.gnt}, 32'h2);
        step();
        bus.req = 2'b00;
        chk("mr_rvalid_pre", {30'h0, bus.rvalid}, 32'h2);
        #1 rst_n = 1'b0;
        #1 chk("mr_rvalid_async", {30'h0, bus.rvalid}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        bus.req = 2'b11; bus.addr[0] = 32'h0; bus.addr[1] = 32'h4;
        mid();
        chk("mr_first_gnt", {30'h0, bus.gnt}, 32'h1);
        step();
        bus.req = 2'b00;
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++)
                if (!bus.req[n] || g_seen[n]) gen(n);
            step();
        end
        bus.req = 2'b00;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
